// File: rtl/event_tag_fifo.sv
// rtl/event_tag_fifo.sv - trigger tag/pattern FIFO, FWFT, optional timestamp column (EVTAG_TIMESTAMP_EN)
module event_tag_fifo #(
  parameter int AW    = 4,
  parameter int ENC_W = 14,
  parameter int SNC_W = 10,
  parameter int PAT_W = 16,
  parameter int AFULL = 2
) (
  input  logic             SYSCLK,
  input  logic             RSTB,
  input  logic             TRIG,
  input  logic [ENC_W-1:0] ENC,
  input  logic [SNC_W-1:0] SNC,
  input  logic             LOCK,
  input  logic [PAT_W-1:0] PATTERN,
  input  logic             RD_POP,
  input  logic             CLR,
  output logic [31:0]      DOUT_TAG,
  output logic [31:0]      DOUT_PAT,
  output logic [31:0]      DOUT_TS,
  output logic             EMPTY,
  output logic             FULL,
  output logic [AW:0]      COUNT,
  output logic [15:0]      OVF_CNT,
  output logic             UNDERFLOW,
  output logic             BUSY_REQ
);

  localparam int DEPTH = 1 << AW;
  localparam int TAG_W = 1 + ENC_W + SNC_W;
  localparam logic [AW:0] DEPTH_C  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] THRESH_C = DEPTH_C - (AW+1)'(AFULL);
  localparam logic [31:0] EMPTY_WORD = 32'hFEFEFEFE;

  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [PAT_W-1:0] pat_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          trig_d;
  logic          push_req;
  logic          push_ok;
  logic          pop_ok;
  logic [AW:0]   count_next;
  logic [TAG_W-1:0] head_tag;
  logic [31:0]   tag_word;
  logic [31:0]   pat_word;

  assign EMPTY    = (COUNT == '0);
  assign FULL     = (COUNT == DEPTH_C);
  assign push_req = TRIG & ~trig_d;
  // A pop on a full buffer frees the slot the simultaneous push needs.
  assign push_ok  = push_req & ~CLR & (~FULL | RD_POP);
  assign pop_ok   = RD_POP & ~EMPTY & ~CLR;

  // Next occupancy; CLR wins over push and pop.
  always_comb begin
    count_next = COUNT;
    if (CLR)
      count_next = '0;
    else if (push_ok && !pop_ok)
      count_next = COUNT + 1'b1;
    else if (!push_ok && pop_ok)
      count_next = COUNT - 1'b1;
  end

  // Trigger edge history; held high in reset so a level already high cannot push.
  always_ff @(posedge SYSCLK) begin
    if (!RSTB)
      trig_d <= 1'b1;
    else
      trig_d <= TRIG;
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge SYSCLK) begin
    if (!RSTB || CLR) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      COUNT     <= '0;
      OVF_CNT   <= '0;
      UNDERFLOW <= 1'b0;
      BUSY_REQ  <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_req && FULL && !RD_POP && OVF_CNT != 16'hFFFF)
        OVF_CNT <= OVF_CNT + 1'b1;
      if (RD_POP && EMPTY)
        UNDERFLOW <= 1'b1;
      COUNT    <= count_next;
      BUSY_REQ <= (count_next >= THRESH_C);
    end
  end

  // Entry storage; contents survive reset and CLR, only pointers are cleared.
  always_ff @(posedge SYSCLK) begin
    if (push_ok) begin
      tag_mem[wr_ptr] <= {LOCK, ENC, SNC};
      pat_mem[wr_ptr] <= PATTERN;
    end
  end

  // Unpack the head entry into the 32-bit register layouts.
  always_comb begin
    head_tag = tag_mem[rd_ptr];
    tag_word = '0;
    tag_word[31] = head_tag[TAG_W-1];
    tag_word[ENC_W+SNC_W-1:0] = head_tag[ENC_W+SNC_W-1:0];
    pat_word = '0;
    pat_word[PAT_W-1:0] = pat_mem[rd_ptr];
  end

  assign DOUT_TAG = EMPTY ? EMPTY_WORD : tag_word;
  assign DOUT_PAT = EMPTY ? EMPTY_WORD : pat_word;

`ifdef EVTAG_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_mem [DEPTH];

  // Free-running timestamp; only reset clears it, CLR does not.
  always_ff @(posedge SYSCLK) begin
    if (!RSTB)
      ts_cnt <= '0;
    else
      ts_cnt <= ts_cnt + 1'b1;
  end

  // Timestamp column written alongside each accepted entry.
  always_ff @(posedge SYSCLK) begin
    if (push_ok)
      ts_mem[wr_ptr] <= ts_cnt;
  end

  assign DOUT_TS = EMPTY ? EMPTY_WORD : ts_mem[rd_ptr];
`else
  assign DOUT_TS = 32'd0;
`endif

endmodule

// File: tb/tb_event_tag_fifo.sv
// tb/tb_event_tag_fifo.sv - directed self-checking bench for event_tag_fifo
module tb_event_tag_fifo;

  logic        SYSCLK = 1'b0;
  logic        RSTB;
  logic        TRIG;
  logic [13:0] ENC;
  logic [9:0]  SNC;
  logic        LOCK;
  logic [15:0] PATTERN;
  logic        RD_POP;
  logic        CLR;
  logic [31:0] DOUT_TAG;
  logic [31:0] DOUT_PAT;
  logic [31:0] DOUT_TS;
  logic        EMPTY;
  logic        FULL;
  logic [4:0]  COUNT;
  logic [15:0] OVF_CNT;
  logic        UNDERFLOW;
  logic        BUSY_REQ;

  int checks = 0;
  int failures = 0;

  event_tag_fifo dut (
    .SYSCLK(SYSCLK), .RSTB(RSTB), .TRIG(TRIG), .ENC(ENC), .SNC(SNC), .LOCK(LOCK),
    .PATTERN(PATTERN), .RD_POP(RD_POP), .CLR(CLR), .DOUT_TAG(DOUT_TAG),
    .DOUT_PAT(DOUT_PAT), .DOUT_TS(DOUT_TS), .EMPTY(EMPTY), .FULL(FULL),
    .COUNT(COUNT), .OVF_CNT(OVF_CNT), .UNDERFLOW(UNDERFLOW), .BUSY_REQ(BUSY_REQ)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_push(input logic [13:0] e, input logic [15:0] p);
    ENC = e;
    PATTERN = p;
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
    tick();
  endtask

  task automatic pop();
    RD_POP = 1'b1;
    tick();
    RD_POP = 1'b0;
  endtask

  logic [31:0] ts_a;
  logic [31:0] ts_b;
  logic [31:0] exp_ts_empty;

  initial begin
`ifdef EVTAG_TIMESTAMP_EN
    exp_ts_empty = 32'hFEFEFEFE;
`else
    exp_ts_empty = 32'd0;
`endif
    RSTB = 1'b0; TRIG = 1'b1; ENC = '0; SNC = '0; LOCK = 1'b0;
    PATTERN = '0; RD_POP = 1'b0; CLR = 1'b0;
    tick(); tick(); tick();
    RSTB = 1'b1;
    tick(); tick();

    // 1: TRIG high through reset release must not push
    chk("rst_empty", {31'd0, EMPTY}, 32'd1);
    chk("rst_count", {27'd0, COUNT}, 32'd0);
    chk("rst_tag", DOUT_TAG, 32'hFEFEFEFE);
    chk("rst_pat", DOUT_PAT, 32'hFEFEFEFE);
    chk("rst_ts", DOUT_TS, exp_ts_empty);
    chk("rst_flags", {28'd0, FULL, UNDERFLOW, BUSY_REQ, 1'b0}, 32'd0);
    chk("rst_ovf", {16'd0, OVF_CNT}, 32'd0);
    TRIG = 1'b0;
    tick();

    // 2: single entry, FWFT visibility and pop
    ENC = 14'h0123; SNC = 10'h005; LOCK = 1'b1; PATTERN = 16'hA5A5;
    TRIG = 1'b1;
    tick();
    chk("one_tag", DOUT_TAG, 32'h80048C05);
    chk("one_pat", DOUT_PAT, 32'h0000A5A5);
    chk("one_count", {27'd0, COUNT}, 32'd1);
    chk("one_empty", {31'd0, EMPTY}, 32'd0);
    TRIG = 1'b0;
    pop();
    chk("one_pop_empty", {31'd0, EMPTY}, 32'd1);
    chk("one_pop_tag", DOUT_TAG, 32'hFEFEFEFE);

    // 3: 18 edges into 16 slots
    LOCK = 1'b0; SNC = 10'h3AB;
    for (int i = 0; i < 18; i++) begin
      ENC = 14'(i);
      PATTERN = 16'h1000 + 16'(i);
      TRIG = 1'b1;
      tick();
      chk($sformatf("busy_push%0d", i + 1), {31'd0, BUSY_REQ}, {31'd0, (i + 1) >= 14});
      TRIG = 1'b0;
      tick();
    end
    chk("fill_count", {27'd0, COUNT}, 32'd16);
    chk("fill_full", {31'd0, FULL}, 32'd1);
    chk("fill_ovf", {16'd0, OVF_CNT}, 32'd2);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_tag%0d", i), DOUT_TAG, {8'h00, 14'(i), 10'h3AB});
      chk($sformatf("drain_pat%0d", i), DOUT_PAT, 32'h00001000 + 32'(i));
      pop();
    end
    chk("drain_empty", {31'd0, EMPTY}, 32'd1);
    chk("drain_busy", {31'd0, BUSY_REQ}, 32'd0);

    // 4: simultaneous push and pop while full
    for (int i = 0; i < 16; i++)
      edge_push(14'(100 + i), 16'(i));
    chk("full2", {31'd0, FULL}, 32'd1);
    ENC = 14'h3FFF; PATTERN = 16'hBEEF;
    TRIG = 1'b1; RD_POP = 1'b1;
    tick();
    TRIG = 1'b0; RD_POP = 1'b0;
    chk("pp_count", {27'd0, COUNT}, 32'd16);
    chk("pp_ovf", {16'd0, OVF_CNT}, 32'd2);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("pp_tag%0d", i), DOUT_TAG,
          (i < 15) ? {8'h00, 14'(101 + i), 10'h3AB} : {8'h00, 14'h3FFF, 10'h3AB});
      pop();
    end
    chk("pp_empty", {31'd0, EMPTY}, 32'd1);

    // 6: timestamps on edges 100 cycles apart
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
    for (int i = 0; i < 99; i++) tick();
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
    ts_a = DOUT_TS;
    pop();
    ts_b = DOUT_TS;
    pop();
`ifdef EVTAG_TIMESTAMP_EN
    chk("ts_diff", ts_b - ts_a, 32'd100);
`else
    chk("ts_zero_a", ts_a, 32'd0);
    chk("ts_zero_b", ts_b, 32'd0);
`endif

    // 5: underflow, push+pop on empty, CLR with edge
    pop();
    chk("uf_flag", {31'd0, UNDERFLOW}, 32'd1);
    chk("uf_count", {27'd0, COUNT}, 32'd0);
    TRIG = 1'b1; RD_POP = 1'b1;
    tick();
    TRIG = 1'b0; RD_POP = 1'b0;
    chk("ep_count", {27'd0, COUNT}, 32'd1);
    tick();
    CLR = 1'b1; TRIG = 1'b1;
    tick();
    CLR = 1'b0;
    chk("clr_count", {27'd0, COUNT}, 32'd0);
    chk("clr_uf", {31'd0, UNDERFLOW}, 32'd0);
    chk("clr_ovf", {16'd0, OVF_CNT}, 32'd0);
    tick();
    chk("clr_lost", {31'd0, EMPTY}, 32'd1);
    TRIG = 1'b0;
    tick();

    // reset mid-operation discards entries
    edge_push(14'h0042, 16'h0042);
    chk("mid_count", {27'd0, COUNT}, 32'd1);
    RSTB = 1'b0;
    tick();
    RSTB = 1'b1;
    tick();
    chk("mid_rst_empty", {31'd0, EMPTY}, 32'd1);
    chk("mid_rst_tag", DOUT_TAG, 32'hFEFEFEFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
